// File: rtl/pwm_gpio_regbank.sv
// pwm_gpio_regbank
//   Register bank for a GPIO block and NUM_PWM PWM channels, with a
//   one-cycle registered read port and a byte-strobed write port.
//   Optional feature: define PWM_GPIO_REGBANK_IRQ_EN to build the GPIO
//   rising-edge interrupt logic. Without it, IRQ_STATUS and IRQ_MASK read
//   as zero, ignore writes, and irq is tied low.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   write_*            write request: word address, data, byte enables
//   read_en/read_addr  read request
//   read_data/_valid/_err  registered read response
//   gpio_in/gpio_out   asynchronous input pins / driven output pins
//   pwm_boundary       per-channel period-end pulse from the PWM cores
//   pwm_en/_duty/_period   active channel enables and values (32 bits per channel)
//   irq                level interrupt, OR of (IRQ_STATUS & IRQ_MASK)
module pwm_gpio_regbank #(
  parameter int NUM_PWM    = 4,
  parameter int GPIO_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    write_en,
  input  logic [ADDR_WIDTH-1:0]   write_addr,
  input  logic [31:0]             write_data,
  input  logic [3:0]              write_strb,
  input  logic                    read_en,
  input  logic [ADDR_WIDTH-1:0]   read_addr,
  output logic [31:0]             read_data,
  output logic                    read_valid,
  output logic                    read_err,
  input  logic [GPIO_WIDTH-1:0]   gpio_in,
  output logic [GPIO_WIDTH-1:0]   gpio_out,
  input  logic [NUM_PWM-1:0]      pwm_boundary,
  output logic [NUM_PWM-1:0]      pwm_en,
  output logic [32*NUM_PWM-1:0]   pwm_duty,
  output logic [32*NUM_PWM-1:0]   pwm_period,
  output logic                    irq
);

  localparam logic [ADDR_WIDTH-1:0] A_GPIO_OUT = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_GPIO_IN  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_PWM_EN   = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_IRQ_STAT = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_IRQ_MASK = ADDR_WIDTH'(4);
  localparam logic [31:0]           PERIOD_RST = 32'd1000;

  // Expand the 4 byte enables into a 32-bit bit mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
    return m;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [31:0] m);
    return (old_v & ~m) | (new_v & m);
  endfunction

  logic [31:0] wmask;
  assign wmask = strb_mask(write_strb);

  // GPIO output and PWM enable registers; unused upper bits are dropped
  // by the width cast and so always read back as 0.
  logic [GPIO_WIDTH-1:0] gpio_out_q, gpio_out_d;
  logic [NUM_PWM-1:0]    pwm_en_q, pwm_en_d;

  assign gpio_out_d = (write_en && write_addr == A_GPIO_OUT)
                    ? GPIO_WIDTH'(merge(32'(gpio_out_q), write_data, wmask)) : gpio_out_q;
  assign pwm_en_d   = (write_en && write_addr == A_PWM_EN)
                    ? NUM_PWM'(merge(32'(pwm_en_q), write_data, wmask)) : pwm_en_q;

  // Two-flop synchronizer for the asynchronous pins.
  logic [GPIO_WIDTH-1:0] gpio_meta_q, gpio_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_out_q  <= '0;
      pwm_en_q    <= '0;
      gpio_meta_q <= '0;
      gpio_sync_q <= '0;
    end else begin
      gpio_out_q  <= gpio_out_d;
      pwm_en_q    <= pwm_en_d;
      gpio_meta_q <= gpio_in;
      gpio_sync_q <= gpio_meta_q;
    end
  end

  assign gpio_out = gpio_out_q;
  assign pwm_en   = pwm_en_q;

  logic [GPIO_WIDTH-1:0] irq_status_rd, irq_mask_rd;

`ifdef PWM_GPIO_REGBANK_IRQ_EN
  logic [GPIO_WIDTH-1:0] gpio_prev_q, irq_status_q, irq_status_d, irq_mask_q, irq_mask_d;
  logic                  irq_q;

  always_comb begin
    irq_status_d = irq_status_q;
    if (write_en && write_addr == A_IRQ_STAT)
      irq_status_d = irq_status_q & ~GPIO_WIDTH'(write_data & wmask);
    // A new edge wins over a simultaneous write-1-to-clear.
    irq_status_d = irq_status_d | (gpio_sync_q & ~gpio_prev_q);
  end

  assign irq_mask_d = (write_en && write_addr == A_IRQ_MASK)
                    ? GPIO_WIDTH'(merge(32'(irq_mask_q), write_data, wmask)) : irq_mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_prev_q  <= '0;
      irq_status_q <= '0;
      irq_mask_q   <= '0;
      irq_q        <= 1'b0;
    end else begin
      gpio_prev_q  <= gpio_sync_q;
      irq_status_q <= irq_status_d;
      irq_mask_q   <= irq_mask_d;
      irq_q        <= |(irq_status_q & irq_mask_q);
    end
  end

  assign irq_status_rd = irq_status_q;
  assign irq_mask_rd   = irq_mask_q;
  assign irq           = irq_q;
`else
  assign irq_status_rd = '0;
  assign irq_mask_rd   = '0;
  assign irq           = 1'b0;
`endif

  // Per-channel shadow and active registers.
  logic [32*NUM_PWM-1:0] duty_sh_all, per_sh_all;

  for (genvar gi = 0; gi < NUM_PWM; gi++) begin : g_ch
    localparam logic [ADDR_WIDTH-1:0] A_DUTY = ADDR_WIDTH'(8 + 2*gi);
    localparam logic [ADDR_WIDTH-1:0] A_PER  = ADDR_WIDTH'(9 + 2*gi);

    logic [31:0] duty_sh_q, duty_sh_d, per_sh_q, per_sh_d, duty_act_q, per_act_q;
    logic        load;

    // Enabled channels only take new values at a period boundary; disabled
    // channels track the shadow so software sees its write take effect.
    assign load = pwm_en_q[gi] ? pwm_boundary[gi] : 1'b1;

    assign duty_sh_d = (write_en && write_addr == A_DUTY)
                     ? merge(duty_sh_q, write_data, wmask) : duty_sh_q;
    assign per_sh_d  = (write_en && write_addr == A_PER)
                     ? merge(per_sh_q, write_data, wmask) : per_sh_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        duty_sh_q  <= '0;
        per_sh_q   <= PERIOD_RST;
        duty_act_q <= '0;
        per_act_q  <= PERIOD_RST;
      end else begin
        duty_sh_q <= duty_sh_d;
        per_sh_q  <= per_sh_d;
        // Loads the pre-write shadow when a write lands on the same edge.
        if (load) begin
          duty_act_q <= duty_sh_q;
          per_act_q  <= per_sh_q;
        end
      end
    end

    assign pwm_duty[32*gi +: 32]    = duty_act_q;
    assign pwm_period[32*gi +: 32]  = per_act_q;
    assign duty_sh_all[32*gi +: 32] = duty_sh_q;
    assign per_sh_all[32*gi +: 32]  = per_sh_q;
  end

  // Read mux samples current register values, so a same-cycle write to the
  // same address is not visible in this response.
  logic [31:0] rd_data_d;
  logic        rd_err_d;

  always_comb begin
    rd_data_d = 32'hDEAD_BEEF;
    rd_err_d  = 1'b1;
    case (read_addr)
      A_GPIO_OUT: begin rd_data_d = 32'(gpio_out_q);    rd_err_d = 1'b0; end
      A_GPIO_IN:  begin rd_data_d = 32'(gpio_sync_q);   rd_err_d = 1'b0; end
      A_PWM_EN:   begin rd_data_d = 32'(pwm_en_q);      rd_err_d = 1'b0; end
      A_IRQ_STAT: begin rd_data_d = 32'(irq_status_rd); rd_err_d = 1'b0; end
      A_IRQ_MASK: begin rd_data_d = 32'(irq_mask_rd);   rd_err_d = 1'b0; end
      default: begin
        for (int n = 0; n < NUM_PWM; n++) begin
          if (read_addr == ADDR_WIDTH'(8 + 2*n)) begin
            rd_data_d = duty_sh_all[32*n +: 32];
            rd_err_d  = 1'b0;
          end
          if (read_addr == ADDR_WIDTH'(9 + 2*n)) begin
            rd_data_d = per_sh_all[32*n +: 32];
            rd_err_d  = 1'b0;
          end
        end
      end
    endcase
  end

  logic [31:0] read_data_q;
  logic        read_valid_q, read_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      read_err_q   <= 1'b0;
    end else begin
      read_valid_q <= read_en;
      if (read_en) begin
        read_data_q <= rd_data_d;
        read_err_q  <= rd_err_d;
      end
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign read_err   = read_err_q;

endmodule

// File: doc/pwm_gpio_regbank.md
PWM_GPIO_REGBANK -- requirements
Module: pwm_gpio_regbank

Interface
REQ-001 Parameter NUM_PWM, default 4: PWM channel count, legal range 1..8.
REQ-002 Parameter GPIO_WIDTH, default 8: GPIO pin count, legal range 1..32.
REQ-003 Parameter ADDR_WIDTH, default 6: word-address width, SHALL be at least clog2(8+2*NUM_PWM).
REQ-004 Port clk  in  1: single clock, all state updates on rising edge.
REQ-005 Port rst_n  in  1: reset, asynchronous assert, active-low.
REQ-006 Port write_en / write_addr / write_data / write_strb  in  1 / ADDR_WIDTH / 32 / 4: write request, word address, data, byte enables.
REQ-007 Port read_en / read_addr  in  1 / ADDR_WIDTH: read request and word address.
REQ-008 Port read_data / read_valid / read_err  out  32 / 1 / 1: registered read response.
REQ-009 Port gpio_in / gpio_out  in / out  GPIO_WIDTH: asynchronous pins in, driven pins out.
REQ-010 Port pwm_boundary  in  NUM_PWM: per-channel one-cycle pulse at PWM period end.
REQ-011 Port pwm_en / pwm_duty / pwm_period  out  NUM_PWM / 32*NUM_PWM / 32*NUM_PWM: active channel enables and active values, channel n in bits [32n+31:32n].
REQ-012 Port irq  out  1: level interrupt, OR of (IRQ_STATUS & IRQ_MASK).

Function
REQ-013 Map: 0x00 GPIO_OUT rw, 0x01 GPIO_IN ro, 0x02 PWM_EN rw, 0x03 IRQ_STATUS w1c, 0x04 IRQ_MASK rw, 0x08+2n DUTY_SHADOW[n] rw, 0x09+2n PERIOD_SHADOW[n] rw.
REQ-014 Writes SHALL update only the bytes whose write_strb bit is set; unused upper bits read 0.
REQ-015 Writes to read-only or unmapped addresses SHALL change no state.
REQ-016 Read latency SHALL be 1 cycle: read_valid high exactly 1 cycle after read_en, carrying read_data for read_addr.
REQ-017 Unmapped read SHALL return 32'hDEAD_BEEF with read_err=1; otherwise read_err=0.
REQ-018 When read_valid=0, read_data SHALL hold its last value.
REQ-019 gpio_in SHALL pass through a 2-flop synchronizer; GPIO_IN reads the synchronized value.
REQ-020 Channel enabled: active duty/period SHALL load from shadow on the cycle after pwm_boundary[n]; otherwise hold.
REQ-021 Channel disabled: active duty/period SHALL follow shadow with 1-cycle latency.
REQ-022 Shadow write and boundary in the same cycle: active SHALL load the pre-write shadow; the new value applies at the next boundary.
REQ-023 A read and a write in the same cycle to the same address SHALL return the pre-write value.
REQ-024 pwm_en, gpio_out and irq SHALL be registered outputs; irq updates 1 cycle after a status or mask change.

Reset
REQ-025 rst_n low SHALL immediately clear: GPIO_OUT, PWM_EN, IRQ_STATUS, IRQ_MASK, all duty (shadow and active), read_valid, read_err, read_data, irq, synchronizer flops.
REQ-026 rst_n low SHALL immediately set all period values (shadow and active) to 32'd1000.
REQ-027 Reset mid-operation SHALL discard any in-flight read response; read_valid is 0 in the first cycle after deassertion.

Configuration
REQ-028 Macro PWM_GPIO_REGBANK_IRQ_EN defined: IRQ_STATUS[i] SHALL set on a synchronized rising edge of gpio_in[i]; writing 1 clears the bit; a set and a clear in the same cycle SHALL leave the bit set.
REQ-029 Macro undefined: no edge logic; IRQ_STATUS and IRQ_MASK read 0 and ignore writes (no read_err); irq tied to 0.

Verification
REQ-030 Reset, then read all mapped addresses -> GPIO_OUT/PWM_EN/DUTY = 0, PERIOD = 1000, read_valid exactly 1 cycle after read_en.
REQ-031 Write 0xAABBCCDD to GPIO_OUT with strb=4'b0101, GPIO_WIDTH=32 -> readback 0x00BB00DD.
REQ-032 PWM_EN[0]=1; write DUTY_SHADOW[0]=250 -> pwm_duty ch0 stays 0 until pwm_boundary[0], then 250 one cycle later.
REQ-033 Disabled ch1: write PERIOD_SHADOW[1]=500 -> pwm_period ch1 = 500 one cycle later with no boundary pulse.
REQ-034 IRQ_EN build, MASK=0x01, gpio_in[0] 0->1 -> IRQ_STATUS=0x01, irq high within 4 cycles; write 0x01 to 0x03 -> irq low 1 cycle later.
REQ-035 Read 0x05 -> read_data 0xDEADBEEF, read_err=1; write to 0x05 -> all registers unchanged.
